// File: rtl/regfile_mp.sv
// regfile_mp -- multi-ported register file with a post-reset clear sequence.
//
// Two write ports and two combinational read ports, plus a registered debug
// tap. Index 0 reads as zero and ignores writes. After reset the file walks
// indices 1..NREGS-1 writing zero, one per cycle, with busy held high. While
// busy, writes are dropped and reads return zero.
//
// Optional feature (macro REGFILE_BYPASS_EN): when defined, a read whose
// nonzero index matches an accepted write in the same cycle returns the
// write data (port 1 wins on a double match). When undefined, reads see
// the pre-write contents and the new value appears on the following cycle.
//
// Handshake/timing: no valid/ready handshake; write ports are sampled on
// each rising clk edge with weN as a qualifier, read ports are purely
// combinational, and dbg_data is captured on each rising edge (1-cycle
// latency, pre-write value when the tapped register is written that edge).

module regfile_mp #(
  parameter int NBITS = 64,
  parameter int NREGS = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [$clog2(NREGS)-1:0]   waddr0,
  input  logic [$clog2(NREGS)-1:0]   waddr1,
  input  logic [NBITS-1:0]           wdata0,
  input  logic [NBITS-1:0]           wdata1,
  input  logic [$clog2(NREGS)-1:0]   raddr0,
  input  logic [$clog2(NREGS)-1:0]   raddr1,
  output logic [NBITS-1:0]           rdata0,
  output logic [NBITS-1:0]           rdata1,
  input  logic [$clog2(NREGS)-1:0]   dbg_addr,
  output logic [NBITS-1:0]           dbg_data,
  output logic                       busy
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [AW-1:0]   clr_idx_q;
  logic [AW-1:0]   clr_idx_d;

  // Storage; entry 0 exists but is never written and never read out.
  logic [NBITS-1:0] mem [NREGS];

  // Qualified write strobes: only in IDLE, outside reset, never to index 0.
  logic            clr_we;
  logic            wr0_ok;
  logic            wr1_ok;

  // Busy covers both the reset cycles themselves and the clear walk.
  assign busy   = rst | (state_q == ST_CLEAR);
  assign clr_we = ~rst & (state_q == ST_CLEAR);
  assign wr0_ok = ~busy & we0 & (waddr0 != '0);
  assign wr1_ok = ~busy & we1 & (waddr1 != '0);

  // State register: reset always restarts the clear walk from index 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= FIRST_IDX;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Next-state: advance the clear index each CLEAR cycle, leave after the last.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + FIRST_IDX;
      if (clr_idx_q == LAST_IDX) begin
        state_d = ST_IDLE;
      end
    end
  end

  // Register array update: clear walk, or port 0 then port 1 so port 1 wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx_q] <= '0;
    end
    if (wr0_ok) begin
      mem[waddr0] <= wdata0;
    end
    if (wr1_ok) begin
      mem[waddr1] <= wdata1;
    end
  end

  // Read port 0: array lookup, optional same-cycle bypass, then zero masking.
  always_comb begin
    rdata0 = mem[raddr0];
`ifdef REGFILE_BYPASS_EN
    if (wr0_ok && (waddr0 == raddr0)) begin
      rdata0 = wdata0;
    end
    if (wr1_ok && (waddr1 == raddr0)) begin
      rdata0 = wdata1;
    end
`endif
    if (busy || (raddr0 == '0)) begin
      rdata0 = '0;
    end
  end

  // Read port 1: same structure as read port 0.
  always_comb begin
    rdata1 = mem[raddr1];
`ifdef REGFILE_BYPASS_EN
    if (wr0_ok && (waddr0 == raddr1)) begin
      rdata1 = wdata0;
    end
    if (wr1_ok && (waddr1 == raddr1)) begin
      rdata1 = wdata1;
    end
`endif
    if (busy || (raddr1 == '0)) begin
      rdata1 = '0;
    end
  end

  // Debug tap capture: pre-write contents, zero for index 0 or while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data <= '0;
    end else if (busy || (dbg_addr == '0)) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed bench for regfile_mp (NBITS=64, NREGS=32).
// The driver pushes hand-computed expectations into a queue right after
// driving a cycle's inputs; the monitor drains the queue at the following
// falling edge and compares against the selected DUT output.

module tb_regfile_mp;

  localparam int NBITS = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam int SEL_RD0  = 0;
  localparam int SEL_RD1  = 1;
  localparam int SEL_DBG  = 2;
  localparam int SEL_BUSY = 3;

  logic             clk;
  logic             rst;
  logic             we0, we1;
  logic [AW-1:0]    waddr0, waddr1;
  logic [NBITS-1:0] wdata0, wdata1;
  logic [AW-1:0]    raddr0, raddr1;
  logic [NBITS-1:0] rdata0, rdata1;
  logic [AW-1:0]    dbg_addr;
  logic [NBITS-1:0] dbg_data;
  logic             busy;

  logic [NBITS-1:0] exp_q[$];
  int               sel_q[$];
  string            name_q[$];

  int n_total = 0;
  int n_bad   = 0;

  regfile_mp #(.NBITS(NBITS), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1),
    .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy(busy)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor / scoreboard: compare every expectation pushed this cycle.
  always @(negedge clk) begin
    logic [NBITS-1:0] act;
    logic [NBITS-1:0] exp;
    int               sel;
    string            nm;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      sel = sel_q.pop_front();
      nm  = name_q.pop_front();
      case (sel)
        SEL_RD0: act = rdata0;
        SEL_RD1: act = rdata1;
        SEL_DBG: act = dbg_data;
        default: act = {{(NBITS-1){1'b0}}, busy};
      endcase
      n_total++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [NBITS-1:0] v, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic idle_ports();
    we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  // Stimulus
  initial begin
    rst = 1'b1;
    idle_ports();
    raddr0 = 5'd3; raddr1 = 5'd31; dbg_addr = 5'd4;

    // Two reset edges
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out(SEL_BUSY, 64'd1, "rst_busy");
      expect_out(SEL_RD0,  64'd0, "rst_rdata0");
      expect_out(SEL_DBG,  64'd0, "rst_dbg");
    end

    // Clear walk: busy for exactly 31 cycles, writes dropped, reads zero
    rst = 1'b0;
    for (int i = 0; i < NREGS - 1; i++) begin
      raddr0 = AW'(i + 1);
      we0 = 1'b1; waddr0 = 5'd2; wdata0 = 64'hDEAD;
      expect_out(SEL_BUSY, 64'd1, "clear_busy");
      expect_out(SEL_RD0,  64'd0, "clear_rdata0");
      step();
    end
    idle_ports();
    expect_out(SEL_BUSY, 64'd0, "clear_done_busy");

    // All registers zero after clear
    for (int r = 0; r < NREGS; r++) begin
      raddr0 = AW'(r);
      raddr1 = AW'(NREGS - 1 - r);
      expect_out(SEL_RD0, 64'd0, "post_clear_rd0");
      expect_out(SEL_RD1, 64'd0, "post_clear_rd1");
      step();
    end

    // Port priority on same index
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'hAA;
    we1 = 1'b1; waddr1 = 5'd5; wdata1 = 64'hBB;
    step();
    idle_ports();
    raddr0 = 5'd5;
    expect_out(SEL_RD0, 64'hBB, "priority_port1");

    // Two distinct writes in one cycle
    step();
    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'h1111_2222_3333_4444;
    we1 = 1'b1; waddr1 = 5'd9; wdata1 = 64'hDEAD_BEEF;
    step();
    idle_ports();
    raddr0 = 5'd3; raddr1 = 5'd9;
    expect_out(SEL_RD0, 64'h1111_2222_3333_4444, "dual_write_r3");
    expect_out(SEL_RD1, 64'hDEAD_BEEF, "dual_write_r9");

    // Index 0 immutability
    step();
    we0 = 1'b1; waddr0 = 5'd0; wdata0 = 64'hFFFF;
    raddr1 = 5'd0; dbg_addr = 5'd0;
    expect_out(SEL_RD1, 64'd0, "x0_same_cycle");
    step();
    idle_ports();
    expect_out(SEL_RD1, 64'd0, "x0_read");
    expect_out(SEL_DBG, 64'd0, "x0_dbg");

    // Bypass behaviour on reg 7
    step();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'h1111;
    step();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'h1234;
    raddr0 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    expect_out(SEL_RD0, 64'h1234, "bypass_same_cycle");
`else
    expect_out(SEL_RD0, 64'h1111, "no_bypass_same_cycle");
`endif
    step();
    idle_ports();
    expect_out(SEL_RD0, 64'h1234, "bypass_next_cycle");

    // Double match on reg 7: port 1 data wins
    step();
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 64'hA;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 64'hB;
    raddr1 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    expect_out(SEL_RD1, 64'hB, "bypass_double_match");
`else
    expect_out(SEL_RD1, 64'h1234, "no_bypass_double_match");
`endif
    step();
    idle_ports();
    expect_out(SEL_RD1, 64'hB, "double_match_next");

    // Debug tap: pre-write on write edge, new value one edge later
    step();
    we0 = 1'b1; waddr0 = 5'd6; wdata0 = 64'h55;
    dbg_addr = 5'd6;
    step();
    idle_ports();
    expect_out(SEL_DBG, 64'd0, "dbg_prewrite");
    step();
    expect_out(SEL_DBG, 64'h55, "dbg_after_write");

    // Hold in IDLE; also seed a high register
    we1 = 1'b1; waddr1 = 5'd30; wdata1 = 64'hCAFE;
    step();
    idle_ports();
    for (int i = 0; i < 4; i++) step();
    raddr0 = 5'd3; raddr1 = 5'd30;
    expect_out(SEL_RD0, 64'h1111_2222_3333_4444, "hold_r3");
    expect_out(SEL_RD1, 64'hCAFE, "hold_r30");
    step();

    // Reset from IDLE, then reset again at clear cycle 10
    rst = 1'b1;
    raddr0 = 5'd5;
    expect_out(SEL_BUSY, 64'd1, "idle_rst_busy");
    expect_out(SEL_RD0,  64'd0, "idle_rst_rdata0");
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_out(SEL_BUSY, 64'd1, "pre_restart_busy");
      step();
    end
    rst = 1'b1;
    expect_out(SEL_BUSY, 64'd1, "restart_rst_busy");
    step();
    rst = 1'b0;
    for (int i = 0; i < NREGS - 1; i++) begin
      if (i == 25) begin
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'h77;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 64'h88;
      end else begin
        idle_ports();
      end
      expect_out(SEL_BUSY, 64'd1, "restart_busy");
      expect_out(SEL_RD0,  64'd0, "restart_rdata0");
      step();
    end
    idle_ports();
    expect_out(SEL_BUSY, 64'd0, "restart_done_busy");
    raddr0 = 5'd3; raddr1 = 5'd4;
    expect_out(SEL_RD0, 64'd0, "busy_write_dropped_r3");
    expect_out(SEL_RD1, 64'd0, "busy_write_dropped_r4");
    step();
    raddr0 = 5'd30; raddr1 = 5'd5; dbg_addr = 5'd7;
    expect_out(SEL_RD0, 64'd0, "recleared_r30");
    expect_out(SEL_RD1, 64'd0, "recleared_r5");
    step();
    expect_out(SEL_DBG, 64'd0, "recleared_dbg_r7");

    // Drain and report
    step();
    step();
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
